// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch and decode stage of the 16-bit core. It holds the PC and
// fetches one word per instruction from instruction memory over a req/ack
// handshake. Each word is captured in the instruction register (IR), and IR
// is split into the fields used by the control decoder and the datapath. The
// decoder's jump/pcsrc results select the next PC when the instruction
// retires.
//
// Parameters
//   PCW       PC / instruction-memory word-address width (must exceed 13)
//   RESET_PC  PC value loaded by reset
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   imem_req           fetch request (high in FETCH, low while reset is high)
//   imem_addr          fetch word address, always equal to PC
//   imem_ack           memory completes the fetch this cycle
//   imem_rdata         instruction word, valid with imem_ack
//   stall              downstream hold; blocks retirement while high
//   jump, pcsrc        next-PC selects from the control decoder
//   instr_valid        decoded fields are valid (ISSUE state)
//   op/rs/rt/rd/funct  IR fields [15:13]/[12:10]/[9:7]/[6:4]/[3:0]
//   imm                IR[6:0] sign-extended to 16 bits
//   pc_plus1           PC + 1, wrapping
//
// Build option
//   FETCH_PERF_EN  adds perf_retired / perf_stall 32-bit event counters
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int             PCW      = 16,
   parameter logic [PCW-1:0] RESET_PC = '0
) (
   input  logic           clk,
   input  logic           reset,
   output logic           imem_req,
   output logic [PCW-1:0] imem_addr,
   input  logic           imem_ack,
   input  logic [15:0]    imem_rdata,
   input  logic           stall,
   input  logic           jump,
   input  logic           pcsrc,
   output logic           instr_valid,
   output logic [2:0]     op,
   output logic [2:0]     rs,
   output logic [2:0]     rt,
   output logic [2:0]     rd,
   output logic [3:0]     funct,
   output logic [15:0]    imm,
`ifdef FETCH_PERF_EN
   output logic [31:0]    perf_retired,
   output logic [31:0]    perf_stall,
`endif
   output logic [PCW-1:0] pc_plus1
);

   typedef enum logic {
      S_FETCH = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   state_t         state;
   logic [PCW-1:0] pc;
   logic [15:0]    ir;
   logic [PCW-1:0] imm_pc;
   logic [PCW-1:0] next_pc;
   logic           retire;

   // Field decode is purely combinational from IR.
   assign op     = ir[15:13];
   assign rs     = ir[12:10];
   assign rt     = ir[9:7];
   assign rd     = ir[6:4];
   assign funct  = ir[3:0];
   assign imm    = {{9{ir[6]}}, ir[6:0]};
   // Branch offset sign-extended to the PC width so the add wraps modulo 2^PCW.
   assign imm_pc = {{(PCW-7){ir[6]}}, ir[6:0]};

   assign pc_plus1    = pc + PCW'(1);
   assign imem_addr   = pc;
   // Request is masked by reset directly so it drops the instant reset rises,
   // not at the next clock edge.
   assign imem_req    = (state == S_FETCH) && !reset;
   assign instr_valid = (state == S_ISSUE);
   assign retire      = (state == S_ISSUE) && !stall;

   // Next PC on retire: jump beats branch beats sequential. A jump keeps the
   // upper region bits of PC+1 and replaces the low 13 bits from IR.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      next_pc = pc_plus1;
      if (jump) begin
         next_pc = {pc_plus1[PCW-1:13], ir[12:0]};
      end else if (pcsrc) begin
         next_pc = pc_plus1 + imm_pc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         ir    <= 16'h0000;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         case (state)
            S_FETCH: begin
               if (imem_ack) begin
                  ir    <= imem_rdata;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (retire) begin
                  pc    <= next_pc;
                  state <= S_FETCH;
               end
            end
            default: state <= S_FETCH;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_retired <= '0;
         perf_stall   <= '0;
      end else begin
         if (retire) begin
            perf_retired <= perf_retired + 32'd1;
         end
         if ((state == S_ISSUE) && stall) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. The stimulus process plays the memory and
// the control decoder. Each fetch it starts pushes the expected instruction
// into a scoreboard queue. A monitor on the falling clock edge pops an entry
// whenever instr_valid rises, then compares the fetch address, the address
// hold time, the decoded fields and the ISSUE length.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        stall;
   logic        jump;
   logic        pcsrc;
   logic        instr_valid;
   logic [2:0]  op;
   logic [2:0]  rs;
   logic [2:0]  rt;
   logic [2:0]  rd;
   logic [3:0]  funct;
   logic [15:0] imm;
   logic [15:0] pc_plus1;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_retired;
   logic [31:0] perf_stall;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] word;
      int          cycles;  // cycles imem_addr is presented with imem_req
      int          stalls;  // stalled ISSUE cycles before retire
   } exp_t;

   exp_t sb[$];

   fetch_unit #(
      .PCW      (16),
      .RESET_PC (16'h0000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .jump        (jump),
      .pcsrc       (pcsrc),
      .instr_valid (instr_valid),
      .op          (op),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .funct       (funct),
      .imm         (imm),
`ifdef FETCH_PERF_EN
      .perf_retired(perf_retired),
      .perf_stall  (perf_stall),
`endif
      .pc_plus1    (pc_plus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int          req_cnt   = 0;
   int          valid_cnt = 0;
   int          cap_cnt   = 0;
   logic        prev_valid = 1'b0;
   logic        ack_seen   = 1'b0;
   logic [15:0] hold_addr  = '0;
   logic [15:0] cap_addr   = '0;
   exp_t        cur;

   always @(negedge clk) begin
      if (reset) begin
         req_cnt    = 0;
         valid_cnt  = 0;
         prev_valid = 1'b0;
         ack_seen   = 1'b0;
      end else begin
         if (instr_valid && !prev_valid) begin
            check("valid_after_ack", {31'd0, ack_seen}, 32'd1);
            check("sb_depth", sb.size(), 32'd1);
            if (sb.size() > 0) begin
               cur = sb.pop_front();
               check("fetch_addr", {16'd0, cap_addr}, {16'd0, cur.addr});
               check("addr_hold_cycles", cap_cnt, cur.cycles);
               check("ir_fields", {16'd0, op, rs, rt, rd, funct}, {16'd0, cur.word});
               check("imm", {16'd0, imm}, {16'd0, {{9{cur.word[6]}}, cur.word[6:0]}});
               check("pc_plus1", {16'd0, pc_plus1}, {16'd0, cur.addr + 16'd1});
            end
            valid_cnt = 0;
         end
         if (!instr_valid && prev_valid) begin
            check("issue_cycles", valid_cnt, cur.stalls + 1);
         end
         if (instr_valid) valid_cnt++;
         ack_seen = imem_req && imem_ack;
         if (imem_req) begin
            if (req_cnt == 0) hold_addr = imem_addr;
            else check("addr_stable", {16'd0, imem_addr}, {16'd0, hold_addr});
            req_cnt++;
            if (imem_ack) begin
               cap_addr = hold_addr;
               cap_cnt  = req_cnt;
               req_cnt  = 0;
            end
         end
         prev_valid = instr_valid;
      end
   end

   // ---------------- stimulus ----------------
   // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 in ISSUE.
   task automatic do_fetch(input logic [15:0] addr, input logic [15:0] word,
                           input int waits, input int stalls);
      sb.push_back('{addr: addr, word: word, cycles: waits + 1, stalls: stalls});
      jump       = 1'b1;  // must be ignored outside ISSUE
      pcsrc      = 1'b1;
      stall      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 16'hDEAD;
      repeat (waits) begin
         @(posedge clk); #1;
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(posedge clk); #1;
      imem_ack   = 1'b0;
      imem_rdata = 16'hBEEF;
   endtask

   // Called at posedge+1 in ISSUE; returns at posedge+1 after the retire edge.
   task automatic do_issue(input logic [15:0] addr, input logic [15:0] word,
                           input int stalls, input logic j, input logic p);
      jump  = j;
      pcsrc = p;
      stall = (stalls > 0);
      for (int i = 0; i < stalls; i++) begin
         check("stall_req", {31'd0, imem_req}, 32'd0);
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
         check("stall_pc", {16'd0, imem_addr}, {16'd0, addr});
         check("stall_ir", {16'd0, op, rs, rt, rd, funct}, {16'd0, word});
         @(posedge clk); #1;
      end
      stall = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_instr(input logic [15:0] addr, input logic [15:0] word, input int waits,
                           input int stalls, input logic j, input logic p);
      do_fetch(addr, word, waits, stalls);
      do_issue(addr, word, stalls, j, p);
   endtask

`ifdef FETCH_PERF_EN
   logic [31:0] snap_stall;
   logic [31:0] snap_ret;
`endif

   initial begin
      reset      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 16'h0000;
      stall      = 1'b0;
      jump       = 1'b0;
      pcsrc      = 1'b0;
      #2 reset   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_addr", {16'd0, imem_addr}, 32'h0000);
      check("rst_ir", {16'd0, op, rs, rt, rd, funct}, 32'h0000);

      // Release with ack already high: request at 0000 in the first cycle.
      reset = 1'b0;
      #1;
      check("rel_req", {31'd0, imem_req}, 32'd1);
      check("rel_addr", {16'd0, imem_addr}, 32'h0000);

      do_instr(16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0);
      do_instr(16'h0001, 16'hE123, 0, 0, 1'b0, 1'b0);
      do_instr(16'h0002, 16'h1F0F, 0, 0, 1'b0, 1'b0);
      do_instr(16'h0003, 16'h2222, 0, 0, 1'b0, 1'b0);

      // Three wait states then five stalled ISSUE cycles.
      do_fetch(16'h0004, 16'h6A5B, 3, 5);
      check("f6a5b_op", {29'd0, op}, 32'd3);
      check("f6a5b_rs", {29'd0, rs}, 32'd2);
      check("f6a5b_rt", {29'd0, rt}, 32'd4);
      check("f6a5b_rd", {29'd0, rd}, 32'd5);
      check("f6a5b_funct", {28'd0, funct}, 32'hB);
      check("f6a5b_imm", {16'd0, imm}, 32'hFFDB);
`ifdef FETCH_PERF_EN
      snap_stall = perf_stall;
      snap_ret   = perf_retired;
`endif
      do_issue(16'h0004, 16'h6A5B, 5, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
      check("perf_stall_delta", perf_stall - snap_stall, 32'd5);
      check("perf_retired_delta", perf_retired - snap_ret, 32'd1);
`endif

      // Branch -3 from 0005: 0006 + FFFD = 0003.
      do_instr(16'h0005, 16'h807D, 0, 0, 1'b0, 1'b1);
      check("branch_taken", {16'd0, imem_addr}, 32'h0003);
      // Jump back to 0005, then the same branch not taken.
      do_instr(16'h0003, 16'h0005, 0, 0, 1'b1, 1'b0);
      do_instr(16'h0005, 16'h807D, 0, 0, 1'b0, 1'b0);
      check("branch_not_taken", {16'd0, imem_addr}, 32'h0006);
      do_instr(16'h0006, 16'h0005, 0, 0, 1'b1, 1'b0);

      // Climb to 2005 with 128 branches of +63 (each advances PC by 64).
      for (int k = 0; k < 128; k++) begin
         do_instr(16'h0005 + 16'(k * 64), 16'h003F, 0, 0, 1'b0, 1'b1);
      end
      check("climb_addr", {16'd0, imem_addr}, 32'h2005);

      // Jump and branch both asserted: jump wins.
      do_instr(16'h2005, 16'h0040, 0, 0, 1'b1, 1'b1);
      check("jump_target", {16'd0, imem_addr}, 32'h2040);

      // Reset mid-FETCH at 2040 with an ack arriving while reset is high.
      imem_ack = 1'b0;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("midrst_req", {31'd0, imem_req}, 32'd0);
      check("midrst_valid", {31'd0, instr_valid}, 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 16'hFFFF;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_ir", {16'd0, op, rs, rt, rd, funct}, 32'h0000);
      check("midrst_imm", {16'd0, imm}, 32'h0000);
      check("midrst_valid2", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_PERF_EN
      check("midrst_perf", perf_retired | perf_stall, 32'd0);
`endif
      reset = 1'b0;
      #1;
      check("restart_req", {31'd0, imem_req}, 32'd1);
      check("restart_addr", {16'd0, imem_addr}, 32'h0000);
      do_instr(16'h0000, 16'h2A3C, 0, 0, 1'b0, 1'b0);
      check("restart_next", {16'd0, imem_addr}, 32'h0001);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and decode stage for the 16-bit single-cycle-control core. Holds the PC, fetches instructions from instruction memory over a request/acknowledge handshake, and registers each instruction in an instruction register. Splits the instruction into `op`/`funct`/register/immediate fields for the control decoder and datapath. Applies the control decoder's `jump` and `pcsrc` results to choose the next PC.

## Interface
- `PCW`, 16: PC and instruction-memory address width (word addressed).
- `RESET_PC`, 16'h0000: PC value loaded at reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PCW  fetch word address; equals PC.
- `imem_ack`  in  1  memory completes fetch this cycle.
- `imem_rdata`  in  16  instruction word; valid when `imem_ack`=1.
- `stall`  in  1  downstream hold; blocks retirement.
- `jump`  in  1  from control decoder.
- `pcsrc`  in  1  from control decoder (branch & zero).
- `instr_valid`  out  1  decoded fields are valid.
- `op`  out  3  `ir[15:13]`.
- `rs`  out  3  `ir[12:10]`.
- `rt`  out  3  `ir[9:7]`.
- `rd`  out  3  `ir[6:4]`.
- `funct`  out  4  `ir[3:0]`.
- `imm`  out  16  `ir[6:0]` sign-extended.
- `pc_plus1`  out  PCW  PC+1, modulo 2^PCW.

## Operation
- FSM has two states.
  - FETCH: `imem_req`=1, `instr_valid`=0. On `imem_ack`=1, load IR from `imem_rdata` and go to ISSUE. Otherwise stay in FETCH.
  - ISSUE: `imem_req`=0, `instr_valid`=1. If `stall`=1, hold IR, PC and state. If `stall`=0, retire the instruction: update PC and go to FETCH.
- `imem_req` and `instr_valid` are decoded combinationally from the state.
- Next PC on retire (priority order):
  - `jump`=1: `{pc_plus1[PCW-1:13], ir[12:0]}`.
  - else `pcsrc`=1: `pc_plus1 + imm`, truncated to PCW bits.
  - else: `pc_plus1`.
- All PC arithmetic wraps modulo 2^PCW. PC 16'hFFFF increments to 16'h0000.
- Field outputs decode from IR continuously. They are meaningful only while `instr_valid`=1.
- `jump`, `pcsrc` and `imem_ack` are ignored in states where they are not used.
- `imem_rdata` is sampled only in FETCH with `imem_ack`=1.
- Reset, async, any state: state=FETCH, PC=`RESET_PC`, IR=16'h0000, `instr_valid`=0.
  - `imem_req` is forced to 0 while reset is asserted.
  - An in-flight fetch is abandoned. An ack arriving during reset is discarded.

## Timing
- `imem_addr` and `imem_req` are stable from request until the ack cycle.
- Minimum 2 cycles per instruction: the ack cycle plus one ISSUE cycle.
- Each memory wait state adds 1 cycle. Each stalled ISSUE cycle adds 1 cycle.
- IR loads on the clock edge at the end of the ack cycle. `instr_valid` rises in the next cycle.
- On the retiring edge the new PC appears on `imem_addr` with `imem_req`=1 in the same cycle.
- The first request after reset release occurs in the first cycle after deassertion.
- `jump` and `pcsrc` are sampled only on the retiring edge. They are combinational from the current field outputs.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds output `perf_retired` [31:0], counting retired instructions.
  - Adds output `perf_stall` [31:0], counting ISSUE cycles with `stall`=1.
  - Both counters reset to 0 and wrap at 2^32.
- `FETCH_PERF_EN` undefined: neither port nor counter exists. Functional behaviour is identical either way.

## Test plan
- Reset, then release with `imem_ack` held at 1 -> `imem_addr`=0000 with `imem_req`=1 in the first cycle. Sequential fetch then gives addresses 0000, 0001, 0002, with one address change every 2 cycles.
- `imem_ack` delayed 3 cycles at PC 0004 -> `imem_addr` holds 0004 for 4 cycles. `instr_valid` rises 1 cycle after the ack. Fields match the word: 16'h6A5B gives op=3, rs=2, rt=4, rd=5, funct=B.
- Branch at PC 0005 with imm=7'h7D (−3) and `pcsrc`=1 -> next `imem_addr`=0003. The same case with `pcsrc`=0 -> 0006.
- Jump at PC 2005 with `ir[12:0]`=0040, `jump`=1 and `pcsrc`=1 together -> next `imem_addr`=2040 (jump wins).
- `stall`=1 for 5 ISSUE cycles -> IR, PC and `instr_valid`=1 all hold, with no request issued. With `FETCH_PERF_EN`, `perf_stall` increments by 5.
- Assert reset mid-FETCH with an ack arriving during reset -> `imem_req` drops immediately and IR stays 0000. After release, the fetch restarts at `RESET_PC`.
